// File: rtl/mux2_rr_arbiter_pkg.sv
// Purpose: shared state encoding and grant constants for the 2:1 round-robin packet arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux2_rr_arbiter_pkg;

    // Arbiter FSM states: idle/arbitrating, or locked to one channel for a whole packet
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    // Grant encoding, also the value driven on sel
    localparam logic GNT_CH0 = 1'b0;
    localparam logic GNT_CH1 = 1'b1;

endpackage

// File: rtl/mux2to1.sv
// Purpose: generic combinational 2:1 mux (sel=0 -> a, sel=1 -> b).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; steering only.
// Ports: sel (select), a/b (W-bit inputs), y (W-bit output).
module mux2to1 #(
    parameter int W = 8
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/stream_out_reg.sv
// Purpose: one-entry registered output stage with valid/ready handshake.
// Latency: 1 cycle from load to out_valid.
// Backpressure: in_ready low only while holding a beat that downstream is refusing.
// Ports: clk/rst (async active-high), load + load_dat (write side), in_ready (slot can take
//        a beat this cycle), out_valid/out_dat/out_ready (downstream stream).
module stream_out_reg #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_dat,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_dat,
    input  logic         out_ready
);

    // The slot is free if empty, or if its current beat leaves on this same edge,
    // which gives full throughput without a second entry.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_dat   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_dat   <= load_dat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Purpose: round-robin arbiter merging two valid/ready/last packet streams, grant locked per packet.
// Latency: 2 cycles from valid (arbiter idle) to out_valid for a packet's first beat, 1 cycle after.
// Backpressure: granted channel's ready = output slot free; other channel's ready held low.
// Ports: clk, rst (async active-high); in0_*/in1_* input streams; out_* registered output
//        stream; sel = current grant (registered); busy = a packet is locked.
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy
);

    state_t          state;
    logic            last_grant;
    logic            slot_free;
    logic            accept;
    logic [DATA_W:0] beat_mux;
    logic [DATA_W:0] out_dat;

    // sel only changes when leaving IDLE, so in a locked state it always points at
    // the granted channel and can steer data+last directly.
    mux2to1 #(
        .W (DATA_W + 1)
    ) u_beat_mux (
        .sel (sel),
        .a   ({in0_last, in0_data}),
        .b   ({in1_last, in1_data}),
        .y   (beat_mux)
    );

    assign in0_ready = (state == ST_LOCK0) && slot_free;
    assign in1_ready = (state == ST_LOCK1) && slot_free;
    assign accept    = (in0_valid && in0_ready) || (in1_valid && in1_ready);

    stream_out_reg #(
        .W (DATA_W + 1)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_dat  (beat_mux),
        .in_ready  (slot_free),
        .out_valid (out_valid),
        .out_dat   (out_dat),
        .out_ready (out_ready)
    );

    assign out_last = out_dat[DATA_W];
    assign out_data = out_dat[DATA_W-1:0];

    // Arbitration FSM. A lock is taken on the valid seen in IDLE and is never
    // abandoned; only an accepted last beat (or reset) releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sel        <= GNT_CH0;
            busy       <= 1'b0;
            last_grant <= GNT_CH1;
        end else begin
            case (state)
                ST_IDLE: begin
                    // On a tie, channel 0 wins only when channel 1 had the last packet
                    if (in0_valid && (!in1_valid || last_grant == GNT_CH1)) begin
                        state <= ST_LOCK0;
                        sel   <= GNT_CH0;
                        busy  <= 1'b1;
                    end else if (in1_valid) begin
                        state <= ST_LOCK1;
                        sel   <= GNT_CH1;
                        busy  <= 1'b1;
                    end
                end
                ST_LOCK0, ST_LOCK1: begin
                    if (accept && beat_mux[DATA_W]) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        last_grant <= sel;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Purpose: self-checking bench for mux2_rr_arbiter; scoreboard of beats plus per-scenario checks.
// Latency: n/a.
// Backpressure: out_ready driven by the bench.
module tb_mux2_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in0_valid = 1'b0;
    logic [7:0] in0_data = 8'h00;
    logic       in0_last = 1'b0;
    logic       in0_ready;
    logic       in1_valid = 1'b0;
    logic [7:0] in1_data = 8'h00;
    logic       in1_last = 1'b0;
    logic       in1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b1;
    logic       sel;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;

    logic [8:0] sb[$];       // expected {last, data}, pushed when a beat is handed over
    logic [9:0] out_log[$];  // observed {sel, last, data}
    logic [8:0] mon_exp;

    mux2_rr_arbiter #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Output monitor: every output handshake must match the oldest expected beat
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            out_log.push_back({sel, out_last, out_data});
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_extra_beat: got last=%0b data=%h, expected no beat", out_last, out_data);
            end else begin
                mon_exp = sb.pop_front();
                if ({out_last, out_data} !== mon_exp) begin
                    fails++;
                    $display("FAIL sb_beat: got last=%0b data=%h, expected last=%0b data=%h",
                             out_last, out_data, mon_exp[8], mon_exp[7:0]);
                end
            end
        end
    end

    task automatic set_ch(input bit ch, input logic v, input logic [7:0] d, input logic l);
        if (ch == 1'b0) begin
            in0_valid = v; in0_data = d; in0_last = l;
        end else begin
            in1_valid = v; in1_data = d; in1_last = l;
        end
    endtask

    // Sends an n-beat packet (base, base+step, ...). Call at posedge+1.
    // gap_at >= 0: valid dropped for gap_len cycles after that beat is accepted.
    task automatic send_pkt(input bit ch, input logic [7:0] base, input logic [7:0] step,
                            input int n, input int gap_at, input int gap_len);
        logic [7:0] d;
        logic       lst;
        int         waited;
        bit         ok;
        d = base;
        for (int i = 0; i < n; i++) begin
            lst = (i == n - 1);
            set_ch(ch, 1'b1, d, lst);
            waited = 0;
            ok = 1'b0;
            while (!ok) begin
                @(negedge clk);
                if (rst) begin
                    set_ch(ch, 1'b0, 8'h00, 1'b0);
                    return;
                end
                if ((ch == 1'b0) ? in0_ready : in1_ready) begin
                    sb.push_back({lst, d});
                    acc_cnt++;
                    ok = 1'b1;
                end
                @(posedge clk);
                #1;
                if (!ok) begin
                    waited++;
                    if (waited > 200) begin
                        tests++;
                        fails++;
                        $display("FAIL send_timeout: ch%0d beat %h not accepted, expected ready within 200 cycles", ch, d);
                        set_ch(ch, 1'b0, 8'h00, 1'b0);
                        return;
                    end
                end
            end
            if (i == gap_at) begin
                set_ch(ch, 1'b0, 8'h00, 1'b0);
                repeat (gap_len) @(posedge clk);
                #1;
            end
            d = d + step;
        end
        set_ch(ch, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_cycles(3);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if ({out_valid, sel, busy, in0_ready, in1_ready, out_last, out_data} !== 14'h0) begin
                fails++;
                $display("FAIL reset_idle: cycle %0d got ov=%0b sel=%0b busy=%0b r0=%0b r1=%0b last=%0b data=%h, expected all 0",
                         i, out_valid, sel, busy, in0_ready, in1_ready, out_last, out_data);
            end
        end
        idle_cycles(1);
    endtask

    task automatic test_tie;
        logic [9:0] exp_log[4];
        exp_log[0] = {1'b0, 1'b1, 8'hA0};
        exp_log[1] = {1'b1, 1'b1, 8'hB0};
        exp_log[2] = {1'b0, 1'b1, 8'hA0};
        exp_log[3] = {1'b1, 1'b1, 8'hB0};
        out_log.delete();
        out_ready = 1'b1;
        fork
            begin repeat (2) send_pkt(1'b0, 8'hA0, 8'h00, 1, -1, 0); end
            begin repeat (2) send_pkt(1'b1, 8'hB0, 8'h00, 1, -1, 0); end
        join
        idle_cycles(4);
        tests++;
        if (out_log.size() != 4) begin
            fails++;
            $display("FAIL tie_count: got %0d beats, expected 4", out_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (out_log[i] !== exp_log[i]) begin
                    fails++;
                    $display("FAIL tie_order[%0d]: got sel/last/data %h, expected %h", i, out_log[i], exp_log[i]);
                end
            end
        end
    endtask

    task automatic test_single;
        out_log.delete();
        out_ready = 1'b1;
        fork
            send_pkt(1'b0, 8'h11, 8'h11, 3, -1, 0);
            begin
                @(negedge clk);
                tests++;
                if (busy !== 1'b0) begin
                    fails++; $display("FAIL single_busy_pre: got %0b, expected 0", busy);
                end
                @(negedge clk);
                tests++;
                if ({busy, out_valid} !== 2'b10) begin
                    fails++; $display("FAIL single_lock: got busy=%0b ov=%0b, expected busy=1 ov=0", busy, out_valid);
                end
                @(negedge clk);
                tests++;
                if ({out_valid, out_last, out_data} !== {2'b10, 8'h11}) begin
                    fails++; $display("FAIL single_beat0: got ov=%0b last=%0b data=%h, expected 1/0/11", out_valid, out_last, out_data);
                end
                @(negedge clk);
                tests++;
                if ({out_valid, out_last, out_data} !== {2'b10, 8'h22}) begin
                    fails++; $display("FAIL single_beat1: got ov=%0b last=%0b data=%h, expected 1/0/22", out_valid, out_last, out_data);
                end
                @(negedge clk);
                tests++;
                if ({out_valid, out_last, out_data, busy} !== {2'b11, 8'h33, 1'b0}) begin
                    fails++; $display("FAIL single_beat2: got ov=%0b last=%0b data=%h busy=%0b, expected 1/1/33/0",
                                      out_valid, out_last, out_data, busy);
                end
                @(negedge clk);
                tests++;
                if (out_valid !== 1'b0) begin
                    fails++; $display("FAIL single_drain: got ov=%0b, expected 0", out_valid);
                end
            end
        join
        idle_cycles(3);
    endtask

    task automatic test_backpressure;
        int w;
        out_log.delete();
        out_ready = 1'b0;
        fork
            send_pkt(1'b1, 8'h01, 8'h01, 4, -1, 0);
            begin
                w = 0;
                @(negedge clk);
                while (!out_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                for (int i = 0; i < 3; i++) begin
                    tests++;
                    if ({out_valid, out_data, in1_ready} !== {1'b1, 8'h01, 1'b0}) begin
                        fails++;
                        $display("FAIL bp_hold[%0d]: got ov=%0b data=%h r1=%0b, expected 1/01/0", i, out_valid, out_data, in1_ready);
                    end
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle_cycles(4);
        tests++;
        if (out_log.size() != 4) begin
            fails++;
            $display("FAIL bp_count: got %0d beats, expected 4", out_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (out_log[i][7:0] !== 8'(i + 1)) begin
                    fails++;
                    $display("FAIL bp_order[%0d]: got %h, expected %h", i, out_log[i][7:0], 8'(i + 1));
                end
            end
        end
    endtask

    task automatic test_lock_gap;
        bit   in0_done;
        int   guard;
        logic [7:0] exp_d[4];
        exp_d[0] = 8'h40; exp_d[1] = 8'h41; exp_d[2] = 8'h42; exp_d[3] = 8'h50;
        in0_done = 1'b0;
        out_log.delete();
        out_ready = 1'b1;
        fork
            begin
                send_pkt(1'b0, 8'h40, 8'h01, 3, 1, 5);
                in0_done = 1'b1;
            end
            begin
                idle_cycles(1);
                send_pkt(1'b1, 8'h50, 8'h01, 1, -1, 0);
            end
            begin
                idle_cycles(1);
                guard = 0;
                while (!in0_done && guard < 300) begin
                    @(negedge clk);
                    guard++;
                    if (!in0_done) begin
                        tests++;
                        if ({in1_ready, sel} !== 2'b00) begin
                            fails++;
                            $display("FAIL gap_lock: got r1=%0b sel=%0b, expected r1=0 sel=0", in1_ready, sel);
                        end
                    end
                end
            end
        join
        idle_cycles(4);
        tests++;
        if (out_log.size() != 4) begin
            fails++;
            $display("FAIL gap_count: got %0d beats, expected 4", out_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (out_log[i][7:0] !== exp_d[i]) begin
                    fails++;
                    $display("FAIL gap_order[%0d]: got %h, expected %h", i, out_log[i][7:0], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int base;
        int w;
        base = acc_cnt;
        out_ready = 1'b1;
        fork
            send_pkt(1'b0, 8'h60, 8'h01, 4, -1, 0);
            begin
                w = 0;
                while (acc_cnt < base + 2 && w < 50) begin
                    @(negedge clk);
                    #1;
                    w++;
                end
                @(posedge clk);
                #3;
                tests++;
                if ({out_valid, busy} !== 2'b11) begin
                    fails++;
                    $display("FAIL rstmid_pre: got ov=%0b busy=%0b, expected 1/1", out_valid, busy);
                end
                rst = 1'b1;
                #1;
                tests++;
                if ({out_valid, busy, sel, in0_ready, in1_ready} !== 5'b0) begin
                    fails++;
                    $display("FAIL rstmid_async: got ov=%0b busy=%0b sel=%0b r0=%0b r1=%0b, expected all 0",
                             out_valid, busy, sel, in0_ready, in1_ready);
                end
            end
        join
        sb.delete();
        out_log.delete();
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(1);
        send_pkt(1'b1, 8'h70, 8'h01, 2, -1, 0);
        idle_cycles(4);
        tests++;
        if (out_log.size() != 2) begin
            fails++;
            $display("FAIL rstmid_count: got %0d beats, expected 2", out_log.size());
        end else begin
            tests++;
            if (out_log[0] !== {2'b10, 8'h70} || out_log[1] !== {2'b11, 8'h71}) begin
                fails++;
                $display("FAIL rstmid_after: got %h %h, expected %h %h", out_log[0], out_log[1], {2'b10, 8'h70}, {2'b11, 8'h71});
            end
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_backpressure();
        test_lock_gap();
        test_reset_mid();
        idle_cycles(5);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d undelivered beats, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
